// File: rtl/rgb_to_binary.sv
// Streaming RGB-to-binary converter: two-stage luma/threshold pipeline with
// valid/ready handshakes, raster position tagging and a per-frame control FSM.
module rgb_to_binary #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rgb_pixel_r,
  input  logic [7:0]  rgb_pixel_g,
  input  logic [7:0]  rgb_pixel_b,
  input  logic        rgb_pixel_valid,
  output logic        rgb_pixel_ready,
  input  logic [7:0]  threshold,
  output logic [7:0]  gray_pixel,
  output logic [7:0]  binary_image_pixel,
  output logic        binary_pixel_valid,
  input  logic        binary_pixel_ready,
  output logic [15:0] out_row,
  output logic [15:0] out_col,
  output logic        out_last,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
  localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
  localparam logic [7:0]  COEF [3] = '{8'd77, 8'd150, 8'd29};

  state_t      state_reg;
  logic [15:0] in_row_reg;
  logic [15:0] in_col_reg;
  logic [7:0]  thr_reg;

  logic        s1_valid_reg;
  logic [7:0]  s1_gray_reg;
  logic [15:0] s1_row_reg;
  logic [15:0] s1_col_reg;
  logic        s1_last_reg;

  logic        advance;
  logic        accepting;
  logic        in_xfer;
  logic        out_xfer;
  logic        in_last;
  logic [7:0]  chan [3];
  logic [15:0] prod [3];
  logic [15:0] luma_sum;
  logic [7:0]  luma;

  // The whole pipeline moves together; it only freezes when the output
  // register is occupied and the consumer is not taking it.
  assign advance   = !binary_pixel_valid || binary_pixel_ready;
  assign accepting = (state_reg == IDLE) || (state_reg == STREAM);
  assign rgb_pixel_ready = rst && accepting && advance;
  assign in_xfer   = rgb_pixel_valid && rgb_pixel_ready;
  assign out_xfer  = binary_pixel_valid && binary_pixel_ready;
  assign in_last   = (in_row_reg == LAST_ROW) && (in_col_reg == LAST_COL);

  assign chan[0] = rgb_pixel_r;
  assign chan[1] = rgb_pixel_g;
  assign chan[2] = rgb_pixel_b;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_mul
      assign prod[gi] = {8'd0, chan[gi]} * {8'd0, COEF[gi]};
    end
  endgenerate

  // Coefficients sum to 256, so the 16-bit sum cannot overflow.
  assign luma_sum = prod[0] + prod[1] + prod[2];
  assign luma     = 8'(luma_sum >> 8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg       <= 1'b0;
      s1_gray_reg        <= 8'd0;
      s1_row_reg         <= 16'd0;
      s1_col_reg         <= 16'd0;
      s1_last_reg        <= 1'b0;
      binary_pixel_valid <= 1'b0;
      gray_pixel         <= 8'd0;
      binary_image_pixel <= 8'd0;
      out_row            <= 16'd0;
      out_col            <= 16'd0;
      out_last           <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= in_xfer;
      if (in_xfer) begin
        s1_gray_reg <= luma;
        s1_row_reg  <= in_row_reg;
        s1_col_reg  <= in_col_reg;
        s1_last_reg <= in_last;
      end
      binary_pixel_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        gray_pixel         <= s1_gray_reg;
        binary_image_pixel <= (s1_gray_reg >= thr_reg) ? 8'hFF : 8'h00;
        out_row            <= s1_row_reg;
        out_col            <= s1_col_reg;
        out_last           <= s1_last_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_row_reg <= 16'd0;
      in_col_reg <= 16'd0;
    end else if (state_reg == DONE) begin
      in_row_reg <= 16'd0;
      in_col_reg <= 16'd0;
    end else if (in_xfer) begin
      if (in_last) begin
        in_row_reg <= 16'd0;
        in_col_reg <= 16'd0;
      end else if (in_col_reg == LAST_COL) begin
        in_row_reg <= in_row_reg + 16'd1;
        in_col_reg <= 16'd0;
      end else begin
        in_col_reg <= in_col_reg + 16'd1;
      end
    end
  end

  // Threshold is captured with pixel (0,0); the previous frame has fully
  // drained by then, so no in-flight pixel sees the new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      thr_reg    <= 8'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state_reg == DRAIN) && out_xfer && out_last;
      case (state_reg)
        IDLE: begin
          if (in_xfer) begin
            thr_reg   <= threshold;
            state_reg <= in_last ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (in_xfer && in_last) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (out_xfer && out_last) state_reg <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_binary.sv
// Directed bench for rgb_to_binary: reset behaviour, single-pixel luma and
// threshold cases, full frames with backpressure and mid-frame threshold change.
module tb_rgb_to_binary;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rgb_pixel_r, rgb_pixel_g, rgb_pixel_b;
  logic        rgb_pixel_valid;
  logic        rgb_pixel_ready;
  logic [7:0]  threshold;
  logic [7:0]  gray_pixel;
  logic [7:0]  binary_image_pixel;
  logic        binary_pixel_valid;
  logic        binary_pixel_ready;
  logic [15:0] out_row, out_col;
  logic        out_last;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  logic [63:0] q_out [$];
  logic [63:0] exp_rec [100];
  logic [7:0]  pr [100];
  logic [7:0]  pg [100];
  logic [7:0]  pb [100];

  rgb_to_binary #(.WIDTH(10), .HEIGHT(10)) dut (
    .clk                (clk),
    .rst                (rst),
    .rgb_pixel_r        (rgb_pixel_r),
    .rgb_pixel_g        (rgb_pixel_g),
    .rgb_pixel_b        (rgb_pixel_b),
    .rgb_pixel_valid    (rgb_pixel_valid),
    .rgb_pixel_ready    (rgb_pixel_ready),
    .threshold          (threshold),
    .gray_pixel         (gray_pixel),
    .binary_image_pixel (binary_image_pixel),
    .binary_pixel_valid (binary_pixel_valid),
    .binary_pixel_ready (binary_pixel_ready),
    .out_row            (out_row),
    .out_col            (out_col),
    .out_last           (out_last),
    .frame_done         (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rec(logic [7:0] gy, logic [7:0] bn,
                                      logic [15:0] row, logic [15:0] col, logic last);
    return {15'd0, gy, bn, row, col, last};
  endfunction

  function automatic int model_gray(int r, int g, int b);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transfers are observed on the falling edge, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      if (binary_pixel_valid && binary_pixel_ready) begin
        q_out.push_back(rec(gray_pixel, binary_image_pixel, out_row, out_col, out_last));
        if (out_last) last_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic drive_px(input int r, input int g, input int b, input int thr);
    rgb_pixel_r = 8'(r);
    rgb_pixel_g = 8'(g);
    rgb_pixel_b = 8'(b);
    threshold   = 8'(thr);
    rgb_pixel_valid = 1'b1;
  endtask

  task automatic single(input string tag, input int r, input int g, input int b,
                        input int thr, input int eg, input int eb);
    do_reset();
    binary_pixel_ready = 1'b1;
    drive_px(r, g, b, thr);
    @(negedge clk); chk({tag, "_ready"}, 64'(rgb_pixel_ready), 64'(1));
    @(posedge clk); #1 rgb_pixel_valid = 1'b0;
    @(negedge clk); chk({tag, "_lat1_valid"}, 64'(binary_pixel_valid), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(binary_pixel_valid), 64'(1));
    chk({tag, "_out"}, rec(gray_pixel, binary_image_pixel, out_row, out_col, out_last),
        rec(8'(eg), 8'(eb), 16'd0, 16'd0, 1'b0));
  endtask

  task automatic build_frame(input int seed, input int thr, input bit zero_first);
    for (int i = 0; i < 100; i++) begin
      int gy;
      pr[i] = 8'((i * 29 + seed) % 256);
      pg[i] = 8'((i * 53 + seed * 3 + 7) % 256);
      pb[i] = 8'((i * 91 + seed * 5 + 3) % 256);
      if (zero_first && i == 0) begin
        pr[i] = 8'd0; pg[i] = 8'd0; pb[i] = 8'd0;
      end
      gy = model_gray(int'(pr[i]), int'(pg[i]), int'(pb[i]));
      exp_rec[i] = rec(8'(gy), (gy >= thr) ? 8'hFF : 8'h00, 16'(i / 10), 16'(i % 10), i == 99);
    end
  endtask

  task automatic feed_frame(input int thr0, input int chg, input int thr1);
    for (int i = 0; i < 100; i++) begin
      bit acc;
      acc = 1'b0;
      drive_px(int'(pr[i]), int'(pg[i]), int'(pb[i]), (i >= chg) ? thr1 : thr0);
      for (int w = 0; w < 200 && !acc; w++) begin
        @(negedge clk); acc = rgb_pixel_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        chk("feed_timeout", 64'(0), 64'(1));
        break;
      end
    end
    rgb_pixel_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int w = 0; w < 50 && done_cnt == prev; w++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(prev + 1));
    chk({tag, "_done_latency"}, 64'(done_cyc - last_cyc), 64'(1));
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, 64'(q_out.size()), 64'(100));
    for (int i = 0; i < q_out.size() && i < 100; i++)
      chk($sformatf("%s_px%0d", tag, i), q_out[i], exp_rec[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int prev;
    rst = 1'b0;
    rgb_pixel_valid = 1'b0;
    binary_pixel_ready = 1'b1;
    threshold = 8'd0;
    rgb_pixel_r = 8'd0; rgb_pixel_g = 8'd0; rgb_pixel_b = 8'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", rec(gray_pixel, binary_image_pixel, out_row, out_col, out_last), 64'(0));
    chk("rst_ready", 64'(rgb_pixel_ready), 64'(0));
    chk("rst_valid", 64'(binary_pixel_valid), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("ready_after_rst", 64'(rgb_pixel_ready), 64'(1));

    single("white_t128", 255, 255, 255, 128, 255, 8'hFF);
    single("g100_t100", 100, 100, 100, 100, 100, 8'hFF);
    single("g100_t101", 100, 100, 100, 101, 100, 8'h00);
    single("red_t128", 255, 0, 0, 128, 76, 8'h00);

    // Fill the pipeline under backpressure, then reset between clock edges.
    do_reset();
    binary_pixel_ready = 1'b0;
    drive_px(255, 255, 255, 128);
    repeat (3) @(posedge clk);
    #1 rgb_pixel_valid = 1'b0;
    @(negedge clk); chk("midrst_pre_valid", 64'(binary_pixel_valid), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("midrst_out", rec(gray_pixel, binary_image_pixel, out_row, out_col, out_last), 64'(0));
    chk("midrst_ready", 64'(rgb_pixel_ready), 64'(0));
    chk("midrst_valid", 64'(binary_pixel_valid), 64'(0));
    chk("midrst_done", 64'(frame_done), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    binary_pixel_ready = 1'b1;
    @(negedge clk); chk("midrst_ready_after", 64'(rgb_pixel_ready), 64'(1));
    drive_px(10, 20, 30, 0);
    @(posedge clk); #1 rgb_pixel_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_first_valid", 64'(binary_pixel_valid), 64'(1));
    chk("midrst_first_out", rec(gray_pixel, binary_image_pixel, out_row, out_col, out_last),
        rec(8'd18, 8'hFF, 16'd0, 16'd0, 1'b0));

    // Frame 1: back-to-back, no backpressure.
    do_reset();
    binary_pixel_ready = 1'b1;
    build_frame(11, 128, 1'b0);
    q_out.delete();
    prev = done_cnt;
    feed_frame(128, 1000, 128);
    @(negedge clk); chk("f1_drain_ready", 64'(rgb_pixel_ready), 64'(0));
    wait_done("f1", prev);
    check_frame("f1");

    // Frame 2: 5-cycle stall mid-frame; threshold input drops to 0 at pixel 50.
    build_frame(77, 128, 1'b0);
    q_out.delete();
    prev = done_cnt;
    fork
      feed_frame(128, 50, 0);
      begin
        repeat (30) @(posedge clk);
        #1 binary_pixel_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          int idx;
          @(negedge clk);
          idx = q_out.size();
          chk($sformatf("f2_stall%0d_ready", k), 64'(rgb_pixel_ready), 64'(0));
          chk($sformatf("f2_stall%0d_valid", k), 64'(binary_pixel_valid), 64'(1));
          chk($sformatf("f2_stall%0d_out", k),
              rec(gray_pixel, binary_image_pixel, out_row, out_col, out_last), exp_rec[idx]);
        end
        @(posedge clk); #1 binary_pixel_ready = 1'b1;
      end
    join
    wait_done("f2", prev);
    check_frame("f2");

    // Frame 3: threshold 0 latched, every pixel including black maps to FF.
    build_frame(140, 0, 1'b1);
    q_out.delete();
    prev = done_cnt;
    feed_frame(0, 1000, 0);
    wait_done("f3", prev);
    check_frame("f3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_to_binary.md
RGB_TO_BINARY -- requirements
Module: rgb_to_binary

Interface
REQ-001 SHALL have parameter WIDTH, default 10, pixels per row (column count).
REQ-002 SHALL have parameter HEIGHT, default 10, rows per frame.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports rgb_pixel_r / rgb_pixel_g / rgb_pixel_b, input, 8 each, input pixel channels.
REQ-006 SHALL have port rgb_pixel_valid, input, 1, input pixel present.
REQ-007 SHALL have port rgb_pixel_ready, output, 1, block accepts input this cycle.
REQ-008 SHALL have port threshold, input, 8, binarisation threshold.
REQ-009 SHALL have port gray_pixel, output, 8, computed luma.
REQ-010 SHALL have port binary_image_pixel, output, 8, 8'hFF or 8'h00.
REQ-011 SHALL have port binary_pixel_valid, output, 1, output pixel present.
REQ-012 SHALL have port binary_pixel_ready, input, 1, downstream accepts output.
REQ-013 SHALL have ports out_row / out_col, output, 16 each, frame position of the current output pixel.
REQ-014 SHALL have port out_last, output, 1, current output is pixel (HEIGHT-1, WIDTH-1).
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse after the last output transfer.

Function
REQ-016 Input transfer SHALL occur when rgb_pixel_valid && rgb_pixel_ready; output transfer SHALL occur when binary_pixel_valid && binary_pixel_ready.
REQ-017 Pipeline SHALL have two register stages (luma, threshold); zero-stall latency from input transfer to binary_pixel_valid SHALL be 2 cycles.
REQ-018 Pipeline SHALL advance when stage-2 is empty or binary_pixel_ready=1; otherwise every stage SHALL hold and outputs SHALL remain stable.
REQ-019 rgb_pixel_ready SHALL be 1 only in IDLE or STREAM and when the pipeline advances this cycle.
REQ-020 Luma SHALL be (77*R + 150*G + 29*B) in a 16-bit unsigned sum, gray = sum[15:8], truncation with no rounding.
REQ-021 binary_image_pixel SHALL be 8'hFF when gray >= latched threshold, else 8'h00.
REQ-022 threshold SHALL be latched on the first input transfer of a frame and held for the whole frame.
REQ-023 Input col counter SHALL increment per input transfer, wrapping WIDTH-1 -> 0 with row +1; row/col/last SHALL travel with the pixel through both stages.
REQ-024 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-025 IDLE -> STREAM SHALL occur on the first input transfer, which is pixel (0,0).
REQ-026 STREAM -> DRAIN SHALL occur on the input transfer of pixel (HEIGHT-1, WIDTH-1).
REQ-027 DRAIN SHALL hold rgb_pixel_ready=0 and SHALL go to DONE on the output transfer carrying out_last=1.
REQ-028 DONE SHALL assert frame_done for exactly one cycle, clear the row/col counters, and return to IDLE.
REQ-029 In DRAIN/DONE, rgb_pixel_valid SHALL be ignored; no input SHALL be accepted or lost.
REQ-030 If an output transfer and an input transfer occur in the same cycle, both SHALL complete with no bubble.
REQ-031 binary_pixel_valid SHALL never deassert without a transfer; each accepted pixel SHALL produce exactly one output.

Reset
REQ-032 While rst=0, the block SHALL be in IDLE, and all outputs SHALL be 0, including rgb_pixel_ready, binary_pixel_valid, out_row, out_col, out_last, frame_done, gray_pixel and binary_image_pixel.
REQ-033 Reset SHALL also clear all counters, pipeline valids and the latched threshold, and SHALL take effect immediately, including mid-frame.
REQ-034 The first cycle after rst rises SHALL show rgb_pixel_ready=1, and the next frame SHALL start at (0,0).

Verification
REQ-035 Reset: assert rst=0 mid-frame -> all outputs 0 immediately; after release, rgb_pixel_ready=1 and the next input is tagged (0,0).
REQ-036 Single pixel (255,255,255), threshold 128 -> 2 cycles later binary_pixel_valid=1, gray 255, binary FF, out_row 0, out_col 0.
REQ-037 Pixel (100,100,100) -> gray 100; threshold 100 gives FF, threshold 101 gives 00; pixel (255,0,0) gives gray 76.
REQ-038 Full frame: 100 back-to-back pixels, binary_pixel_ready=1 -> 100 outputs in raster order, out_last only on (9,9), frame_done 1 cycle after that transfer, rgb_pixel_ready=0 during DRAIN.
REQ-039 Backpressure: binary_pixel_ready=0 for 5 cycles mid-frame -> outputs stable, rgb_pixel_ready drops once the pipeline is full, no loss or duplication after release.
REQ-040 Threshold changed mid-frame from 128 to 0 -> the current frame keeps 128; the next frame uses 0, so all outputs are FF.
